dcache: RTL

DCACHE -- requirements
Module: dcache

---
 rtl/dcache.sv | 114 +++++++++++
 1 files changed

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: 8 lines of 32-bit blocks, byte-addressed CPU side,
// block-wide memory side. Hits are resolved combinationally; misses run a small refill FSM.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t      state;
  logic [31:0] data_array [8];
  logic [2:0]  tag_array  [8];
  logic [7:0]  valid;
  logic [7:0]  dirty;

  logic [2:0]  req_tag;
  logic [2:0]  req_index;
  logic [1:0]  req_offset;
  logic [2:0]  miss_tag;
  logic [2:0]  miss_index;
  logic        access;
  logic        hit;
  logic        store_hit;

  assign req_tag    = ADDRESS[7:5];
  assign req_index  = ADDRESS[4:2];
  assign req_offset = ADDRESS[1:0];
  assign access     = READ | WRITE;
  assign hit        = valid[req_index] & (tag_array[req_index] == req_tag);
  // A store wins over a load when both strobes are high.
  assign store_hit  = (state == IDLE) & WRITE & hit;

  assign READDATA = data_array[req_index][{req_offset, 3'b000} +: 8];
  assign BUSYWAIT = RESET & ((access & ~hit) | (state != IDLE));

  // Data and tag arrays carry no reset; only valid/dirty decide whether a line is usable.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_array[miss_index] <= MEM_READDATA;
      tag_array[miss_index]  <= miss_tag;
    end else if (store_hit) begin
      data_array[req_index][{req_offset, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      miss_tag      <= '0;
      miss_index    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty[req_index] <= 1'b1;
          end else if (access && !hit) begin
            // The miss address is captured so a dropped request still finishes its refill.
            miss_tag   <= req_tag;
            miss_index <= req_index;
            if (dirty[req_index]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_array[req_index], req_index};
              MEM_WRITEDATA <= data_array[req_index];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {req_tag, req_index};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {miss_tag, miss_index};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state    <= UPDATE;
            MEM_READ <= 1'b0;
          end
        end
        UPDATE: begin
          valid[miss_index] <= 1'b1;
          dirty[miss_index] <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
